// File: rtl/bsearch_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state codes, comparator verdict encoding and the probe-counter width helper.
package bsearch_pkg;

    // Controller states, kept as plain constants so older tools and
    // netlists that expect a fixed two-bit code keep working.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef logic [1:0] bsearch_state_t;

    // Verdict bits packed as {greater, less, equal}; a well-formed
    // verdict is exactly one of these one-hot codes.
    localparam logic [2:0] VERDICT_EQ = 3'b001;
    localparam logic [2:0] VERDICT_LT = 3'b010;
    localparam logic [2:0] VERDICT_GT = 3'b100;

    // Probe counter must hold the value WIDTH+1.
    function automatic int probe_cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/binary_search_ctrl.sv
// Successive-approximation search initiator. Presents candidate values to an
// external magnitude comparator and narrows the [lo, hi] interval from each
// verdict until the operand is found, the interval is empty, or a malformed
// verdict arrives.
// Optional build macro: BSEARCH_PROBE_COUNT_EN adds the 'probes' output and a
// guard that stops the search after WIDTH+1 probes without a match.
module binary_search_ctrl
    import bsearch_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             resp_valid,
    input  logic             greater,
    input  logic             less,
    input  logic             equal,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             err
`ifdef BSEARCH_PROBE_COUNT_EN
    ,
    output logic [probe_cnt_width(WIDTH)-1:0] probes
`endif
);

    localparam int PCW = probe_cnt_width(WIDTH);

    // Bounds are one bit wider than the guess so lo can reach 2^WIDTH.
    localparam logic [WIDTH:0]          LO_INIT = '0;
    localparam logic [WIDTH:0]          HI_INIT = {1'b0, {WIDTH{1'b1}}};
    localparam logic signed [WIDTH+1:0] ONE_S   = 1;

    bsearch_state_t   r_state;
    logic [WIDTH:0]   r_lo;
    logic [WIDTH:0]   r_hi;
    logic             r_found;
    logic             r_err;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0]        w_guess;
    logic [2:0]              w_verdict;
    logic signed [WIDTH+1:0] w_guess_s;
    logic signed [WIDTH+1:0] w_lo_next_s;
    logic signed [WIDTH+1:0] w_hi_next_s;
    logic                    w_exhausted;
    logic                    w_guard;

    // Midpoint of the current interval; lo <= hi whenever it is used.
    assign w_guess   = WIDTH'(r_lo + ((r_hi - r_lo) >> 1));
    assign w_verdict = {greater, less, equal};
    assign w_guess_s = $signed({2'b00, w_guess});

    // Candidate bounds after a directional verdict, evaluated in a signed
    // space two bits wider than the guess so guess-1 at zero goes negative
    // instead of wrapping, making the emptiness test a plain comparison.
    always_comb begin
        w_lo_next_s = $signed({1'b0, r_lo});
        w_hi_next_s = $signed({1'b0, r_hi});
        if (w_verdict == VERDICT_GT) begin
            w_hi_next_s = w_guess_s - ONE_S;
        end
        if (w_verdict == VERDICT_LT) begin
            w_lo_next_s = w_guess_s + ONE_S;
        end
    end

    assign w_exhausted = (w_lo_next_s > w_hi_next_s);

`ifdef BSEARCH_PROBE_COUNT_EN
    logic [PCW-1:0] r_probes;
    logic [PCW-1:0] w_probes_next;

    assign w_probes_next = r_probes + 1'b1;
    // A consistent comparator can never need more than WIDTH+1 probes, so
    // reaching that count without a match means the comparator lied.
    assign w_guard       = (w_probes_next == PCW'(WIDTH + 1));
    assign probes        = r_probes;

    // Probe counter: cleared on start, counts accepted verdicts, held in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_probes <= '0;
        end else if ((r_state != ST_PROBE) && start) begin
            r_probes <= '0;
        end else if ((r_state == ST_PROBE) && resp_valid) begin
            r_probes <= w_probes_next;
        end
    end
`else
    assign w_guard = 1'b0;
`endif

    // Search sequencer: interval bookkeeping, verdict handling, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_lo     <= LO_INIT;
            r_hi     <= HI_INIT;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_PROBE;
                        r_lo     <= LO_INIT;
                        r_hi     <= HI_INIT;
                        r_found  <= 1'b0;
                        r_err    <= 1'b0;
                        r_result <= '0;
                    end
                end
                ST_PROBE: begin
                    if (resp_valid) begin
                        case (w_verdict)
                            VERDICT_EQ: begin
                                r_result <= w_guess;
                                r_found  <= 1'b1;
                                r_state  <= ST_DONE;
                            end
                            VERDICT_GT, VERDICT_LT: begin
                                if (w_exhausted || w_guard) begin
                                    // Interval empty, or probe budget spent.
                                    r_found <= 1'b0;
                                    r_err   <= w_guard;
                                    r_state <= ST_DONE;
                                end else begin
                                    r_lo <= (WIDTH+1)'(w_lo_next_s);
                                    r_hi <= (WIDTH+1)'(w_hi_next_s);
                                end
                            end
                            default: begin
                                // No verdict bit, or several at once.
                                r_err   <= 1'b1;
                                r_found <= 1'b0;
                                r_state <= ST_DONE;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state; guess reads zero outside PROBE.
    assign guess_valid = (r_state == ST_PROBE);
    assign done        = (r_state == ST_DONE);
    assign guess       = guess_valid ? w_guess : '0;
    assign found       = r_found;
    assign err         = r_err;
    assign result      = r_result;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Self-checking bench for binary_search_ctrl (WIDTH=4). A behavioural
// responder answers guesses from a hidden target (or with deliberately
// inconsistent/malformed verdicts); a reference model derives the expected
// guess sequence and outcome from the interval-halving rules with integers.
module tb_binary_search_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] guess;
    logic         guess_valid;
    logic         resp_valid = 1'b0;
    logic         greater = 1'b0;
    logic         less = 1'b0;
    logic         equal = 1'b0;
    logic         done;
    logic         found;
    logic [W-1:0] result;
    logic         err;
`ifdef BSEARCH_PROBE_COUNT_EN
    logic [$clog2(W+2)-1:0] probes;
`endif

    binary_search_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .resp_valid  (resp_valid),
        .greater     (greater),
        .less        (less),
        .equal       (equal),
        .done        (done),
        .found       (found),
        .result      (result),
        .err         (err)
`ifdef BSEARCH_PROBE_COUNT_EN
        ,
        .probes      (probes)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Responder modes
    localparam int M_TARGET = 0;  // honest comparator against target
    localparam int M_ALWGT  = 1;  // always answers "greater"
    localparam int M_BAD    = 2;  // greater+less together
    localparam int M_ALWLT  = 3;  // always answers "less"

    int exp_q[$];
    int got_q[$];
    int exp_found, exp_result, exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {greater, less, equal} the bench comparator would give for guess g.
    function automatic logic [2:0] respond(input int mode, input int g, input int t);
        case (mode)
            M_ALWGT: return 3'b100;
            M_BAD:   return 3'b110;
            M_ALWLT: return 3'b010;
            default: begin
                if (g > t) return 3'b100;
                if (g < t) return 3'b010;
                return 3'b001;
            end
        endcase
    endfunction

    // Reference: halve the integer interval [lo, hi] until match or empty.
    task automatic model(input int t, input int mode);
        int lo, hi, g, n;
        logic [2:0] v;
        exp_q.delete();
        lo = 0; hi = (1 << W) - 1; n = 0;
        exp_found = 0; exp_result = 0; exp_err = 0;
        while (1) begin
            g = (lo + hi) / 2;
            exp_q.push_back(g);
            n++;
            v = respond(mode, g, t);
            if (v == 3'b001) begin exp_found = 1; exp_result = g; break; end
            if (v != 3'b100 && v != 3'b010) begin exp_err = 1; break; end
            if (v == 3'b100) hi = g - 1; else lo = g + 1;
`ifdef BSEARCH_PROBE_COUNT_EN
            if (n == W + 1) begin exp_err = 1; break; end
`endif
            if (lo > hi) break;
        end
    endtask

    task automatic run(input string name, input int t, input int mode,
                       input int delay, input bit start_during);
        int cycles, g, n;
        bit timeout;
        model(t, mode);
        got_q.delete();
        timeout = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = start_during;
        cycles = 1;
        while (!done) begin
            if (cycles > 80) begin timeout = 1; break; end
            if (guess_valid) begin
                g = int'(guess);
                for (int d = 0; d < delay; d++) begin
                    resp_valid = 1'b0;
                    @(negedge clk);
                    cycles++;
                    chk({name, "_hold_guess"}, 32'(guess), 32'(g));
                    chk({name, "_hold_valid"}, 32'(guess_valid), 32'd1);
                end
                got_q.push_back(g);
                {greater, less, equal} = respond(mode, g, t);
                resp_valid = 1'b1;
            end
            @(negedge clk);
            cycles++;
            resp_valid = 1'b0;
            {greater, less, equal} = 3'b000;
        end
        start = 1'b0;
        chk({name, "_no_timeout"}, 32'(timeout), 32'd0);
        chk({name, "_probe_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_guess%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_found"}, 32'(found), 32'(exp_found));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        if (exp_found != 0) chk({name, "_result"}, 32'(result), 32'(exp_result));
        if (delay == 0) chk({name, "_latency"}, 32'(cycles), 32'(1 + exp_q.size()));
`ifdef BSEARCH_PROBE_COUNT_EN
        chk({name, "_probes"}, 32'(probes), 32'(exp_q.size()));
`endif
        // DONE is a level: outputs hold while start stays low.
        @(negedge clk);
        chk({name, "_done_held"}, 32'(done), 32'd1);
        chk({name, "_found_held"}, 32'(found), 32'(exp_found));
        chk({name, "_gv_low"}, 32'(guess_valid), 32'd0);
        $display("txn %s target=%0d mode=%0d delay=%0d probes=%0d found=%0d err=%0d",
                 name, t, mode, delay, got_q.size(), found, err);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_gv"}, 32'(guess_valid), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_found"}, 32'(found), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_result"}, 32'(result), 32'd0);
        chk({name, "_guess"}, 32'(guess), 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_gv", 32'(guess_valid), 32'd0);
        $display("txn reset checked");

        // Directed cases
        run("t11",       11, M_TARGET, 0, 1'b0);
        run("t15",       15, M_TARGET, 0, 1'b0);
        run("t0",         0, M_TARGET, 0, 1'b0);
        run("always_gt",  0, M_ALWGT,  0, 1'b0);
        run("malformed",  5, M_BAD,    0, 1'b0);
        run("delay3",     7, M_TARGET, 3, 1'b0);
        run("always_lt",  0, M_ALWLT,  0, 1'b0);
        run("start_in_probe", 9, M_TARGET, 0, 1'b1);

        // rst from DONE clears held results
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_done");
        rst = 1'b0;
        $display("txn rst from DONE");

        // rst mid-PROBE with a verdict in flight
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midprobe_gv", 32'(guess_valid), 32'd1);
        chk("midprobe_guess", 32'(guess), 32'd7);
        rst = 1'b1;
        resp_valid = 1'b1;
        {greater, less, equal} = 3'b001;
        @(negedge clk);
        chk_reset_outputs("rst_probe");
        rst = 1'b0;
        @(negedge clk);
        // Verdicts outside PROBE are ignored
        chk("idle_verdict_ignored_done", 32'(done), 32'd0);
        chk("idle_verdict_ignored_gv", 32'(guess_valid), 32'd0);
        resp_valid = 1'b0;
        {greater, less, equal} = 3'b000;
        $display("txn rst mid-PROBE");

        // Randomized targets, latencies and stray start pulses
        for (int i = 0; i < 20; i++) begin
            run($sformatf("rnd%0d", i), int'($urandom_range(0, (1 << W) - 1)),
                M_TARGET, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
